// File: rtl/color_pkg.sv
// Shared types for the colour unpacker and the downstream colouring checker.
package color_pkg;

  typedef logic [1:0] color_t;

  localparam int COLORS_PER_BYTE = 4;

  // Colour encodings shared with the checker.
  typedef enum logic [1:0] {
    C0 = 2'b00,
    C1 = 2'b01,
    C2 = 2'b10,
    C3 = 2'b11
  } color_code_e;

  // Holder FSM: EMPTY waits for a byte, HOLD walks the four colour slots.
  typedef enum logic {
    HOLDER_EMPTY,
    HOLDER_HOLD
  } holder_state_t;

  // One FIFO entry: the packed byte plus its end-of-frame marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  // Colour slot idx of a packed byte, slot 0 in the LSB pair.
  function automatic color_t pick_color(input logic [7:0] b, input logic [1:0] idx);
    return b[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/color_fifo.sv
// Small synchronous FIFO with async reset and sync flush; head shows the oldest entry.
module color_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers and storage; flush discards everything queued.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = wr_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en && !empty) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/color_unpacker.sv
// Byte-to-colour unpacker: FIFO-buffered packed bytes out as one 2-bit colour per
// handshake, LSB pair first, with frame start/end markers and a frame colour counter.
module color_unpacker
  import color_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out_color,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] LAST_IDX = 2'(COLORS_PER_BYTE - 1);
  localparam int         ENTRY_W  = $bits(fifo_entry_t);

  fifo_entry_t   wr_entry;
  fifo_entry_t   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_wr;
  logic          load;
  logic          handshake;

  holder_state_t state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_q, last_d;
  logic          sof_pend_q, sof_pend_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // A byte offered during flush is dropped even though in_ready may be high.
  assign wr_entry  = '{last: in_last, data: in_data};
  assign fifo_wr   = in_valid && !fifo_full && !flush;
  assign in_ready  = !fifo_full;
  assign handshake = out_valid && out_ready;
  assign frame_cnt = frame_cnt_q;

  color_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (load),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Output view of the holder; colour forced to C0 while nothing is held.
  always_comb begin
    out_valid = (state_q == HOLDER_HOLD);
    out_color = out_valid ? pick_color(byte_q, idx_q) : color_t'(C0);
    out_sof   = out_valid && sof_pend_q;
    out_last  = out_valid && last_q && (idx_q == LAST_IDX);
  end

  // Holder FSM, frame marker and counter next-state; flush overrides all of it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    last_d      = last_q;
    sof_pend_d  = sof_pend_q;
    frame_cnt_d = frame_cnt_q;
    load        = 1'b0;

    if (flush) begin
      state_d     = HOLDER_EMPTY;
      idx_d       = '0;
      sof_pend_d  = 1'b1;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        HOLDER_EMPTY: begin
          if (!fifo_empty) begin
            load    = 1'b1;
            state_d = HOLDER_HOLD;
            idx_d   = '0;
            byte_d  = fifo_head.data;
            last_d  = fifo_head.last;
          end
        end
        HOLDER_HOLD: begin
          if (handshake) begin
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (!fifo_empty) begin
                load   = 1'b1;
                byte_d = fifo_head.data;
                last_d = fifo_head.last;
              end else begin
                state_d = HOLDER_EMPTY;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = HOLDER_EMPTY;
          idx_d   = '0;
        end
      endcase

      if (handshake) begin
        if (sof_pend_q) begin
          frame_cnt_d = CNT_W'(1);
        end else if (frame_cnt_q != {CNT_W{1'b1}}) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        sof_pend_d = out_last;
      end
    end
  end

  // State registers; reset leaves the block waiting for the start of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLDER_EMPTY;
      idx_q       <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      sof_pend_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      sof_pend_q  <= sof_pend_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_color_unpacker.sv
// Self-checking bench for color_unpacker: directed scenarios plus a randomized run
// checked against a colour-stream model kept as a queue of expected colours.
module tb_color_unpacker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       out_color;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_last;
  logic [CNT_W-1:0] frame_cnt;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [1:0]       color;
    logic             sof;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  color_unpacker #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_color (out_color),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_color !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_out_color: got %0d want 0", out_color); end
    n_checks++; if (out_sof !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_sof: got %0b want 0", out_sof); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_last: got %0b want 0", out_last); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (frame_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_single_byte();
    logic [1:0] want;
    in_data = 8'hE4; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_latency_gap: out_valid got %0b want 0", out_valid); end
    step();
    for (int i = 0; i < 4; i++) begin
      want = 2'(i);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid[%0d]: got %0b want 1", i, out_valid); end
      n_checks++; if (out_color !== want) begin n_fail++; $display("[TB] FAIL single_color[%0d]: got %0d want %0d", i, out_color, want); end
      n_checks++; if (out_sof !== (i == 0)) begin n_fail++; $display("[TB] FAIL single_sof[%0d]: got %0b want %0b", i, out_sof, (i == 0)); end
      n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("[TB] FAIL single_last[%0d]: got %0b want %0b", i, out_last, (i == 3)); end
      step();
    end
    n_checks++; if (frame_cnt !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL single_frame_cnt: got %0d want 4", frame_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_idle_after: out_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [7:0] b;
    logic [1:0] want;
    int sent, got, bubbles, sofs, lasts, sof_at, last_at;
    logic started;
    bytes[0] = 8'h1B; bytes[1] = 8'hE4; bytes[2] = 8'h00;
    sent = 0; got = 0; bubbles = 0; sofs = 0; lasts = 0; sof_at = -1; last_at = -1; started = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 12; c++) begin
      in_valid = (sent < 3);
      in_data  = (sent < 3) ? bytes[sent] : 8'h00;
      in_last  = (sent == 2);
      if (out_valid) begin
        b = bytes[got / 4];
        want = b[2 * (got % 4) +: 2];
        n_checks++; if (out_color !== want) begin n_fail++; $display("[TB] FAIL b2b_color[%0d]: got %0d want %0d", got, out_color, want); end
        if (out_sof) begin sofs++; sof_at = got; end
        if (out_last) begin lasts++; last_at = got; end
        got++;
        started = 1'b1;
      end else if (started) begin
        bubbles++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (got != 12) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d colours want 12", got); end
    n_checks++; if (bubbles != 0) begin n_fail++; $display("[TB] FAIL b2b_bubbles: got %0d want 0", bubbles); end
    n_checks++; if (sofs != 1 || sof_at != 0) begin n_fail++; $display("[TB] FAIL b2b_sof: got %0d at %0d want 1 at 0", sofs, sof_at); end
    n_checks++; if (lasts != 1 || last_at != 11) begin n_fail++; $display("[TB] FAIL b2b_last: got %0d at %0d want 1 at 11", lasts, last_at); end
    n_checks++; if (frame_cnt !== CNT_W'(12)) begin n_fail++; $display("[TB] FAIL b2b_frame_cnt: got %0d want 12", frame_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0] bytes [6];
    logic [7:0] b;
    logic [1:0] want, first_color;
    logic seen;
    int sent, got, changes;
    for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
    sent = 0; got = 0; changes = 0; seen = 1'b0; first_color = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (sent < 6);
      in_data  = (sent < 6) ? bytes[sent] : 8'h00;
      in_last  = (sent == 5);
      if (out_valid) begin
        if (!seen) begin first_color = out_color; seen = 1'b1; end
        else if (out_color !== first_color) changes++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    b = bytes[0];
    n_checks++; if (sent != 5) begin n_fail++; $display("[TB] FAIL stall_accepted: got %0d want 5", sent); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready: got %0b want 0", in_ready); end
    n_checks++; if (changes != 0) begin n_fail++; $display("[TB] FAIL stall_color_stable: %0d changes want 0", changes); end
    n_checks++; if (out_valid !== 1'b1 || out_color !== b[1:0]) begin n_fail++; $display("[TB] FAIL stall_held: valid %0b color %0d want 1 %0d", out_valid, out_color, b[1:0]); end
    out_ready = 1'b1;
    for (int c = 0; c < 100 && got < 24; c++) begin
      in_valid = (sent < 6);
      in_data  = (sent < 6) ? bytes[sent] : 8'h00;
      in_last  = (sent == 5);
      if (out_valid) begin
        b = bytes[got / 4];
        want = b[2 * (got % 4) +: 2];
        n_checks++; if (out_color !== want) begin n_fail++; $display("[TB] FAIL stall_color[%0d]: got %0d want %0d", got, out_color, want); end
        n_checks++; if (out_sof !== (got == 0) || out_last !== (got == 23)) begin n_fail++; $display("[TB] FAIL stall_marks[%0d]: sof %0b last %0b want %0b %0b", got, out_sof, out_last, (got == 0), (got == 23)); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (got != 24) begin n_fail++; $display("[TB] FAIL stall_count: got %0d want 24", got); end
    n_checks++; if (frame_cnt !== CNT_MAX) begin n_fail++; $display("[TB] FAIL stall_frame_cnt_sat: got %0d want %0d", frame_cnt, CNT_MAX); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_in_ready_after: got %0b want 1", in_ready); end
  endtask

  task automatic test_toggle();
    logic [1:0] held_color, want;
    logic held;
    int got, stalls;
    in_data = 8'hE4; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    got = 0; stalls = 0; held = 1'b0; held_color = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c % 2 == 0);
      if (out_valid) begin
        if (held) begin
          n_checks++; if (out_color !== held_color) begin n_fail++; $display("[TB] FAIL toggle_hold: got %0d want %0d", out_color, held_color); end
        end
        if (out_ready) begin
          want = 2'(got);
          n_checks++; if (out_color !== want) begin n_fail++; $display("[TB] FAIL toggle_color[%0d]: got %0d want %0d", got, out_color, want); end
          got++;
          held = 1'b0;
        end else begin
          stalls++;
          held = 1'b1;
          held_color = out_color;
        end
      end
      step();
    end
    n_checks++; if (got != 4) begin n_fail++; $display("[TB] FAIL toggle_count: got %0d want 4", got); end
    n_checks++; if (stalls != 4) begin n_fail++; $display("[TB] FAIL toggle_stalls: got %0d want 4", stalls); end
    n_checks++; if (frame_cnt !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL toggle_frame_cnt: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    in_data = 8'hE4; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    n_checks++; if (out_valid !== 1'b1 || out_color !== 2'b10) begin n_fail++; $display("[TB] FAIL rstmid_pre: valid %0b color %0d want 1 2", out_valid, out_color); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_color !== 2'b00) begin n_fail++; $display("[TB] FAIL rstmid_async: valid %0b color %0d want 0 0", out_valid, out_color); end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_cnt !== '0) begin n_fail++; $display("[TB] FAIL rstmid_after: in_ready %0b valid %0b cnt %0d want 1 0 0", in_ready, out_valid, frame_cnt); end
    in_data = 8'h1B; in_last = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_color !== 2'b11) begin n_fail++; $display("[TB] FAIL rstmid_sof: valid %0b sof %0b color %0d want 1 1 3", out_valid, out_sof, out_color); end
    step();
    n_checks++; if (frame_cnt !== CNT_W'(1)) begin n_fail++; $display("[TB] FAIL rstmid_frame_cnt: got %0d want 1", frame_cnt); end
    step(); step(); step();
    n_checks++; if (out_valid !== 1'b0 || frame_cnt !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL rstmid_drain: valid %0b cnt %0d want 0 4", out_valid, frame_cnt); end
  endtask

  task automatic test_flush();
    int residue;
    out_ready = 1'b0;
    in_data = 8'h5A; in_last = 1'b0; in_valid = 1'b1;
    step();
    in_data = 8'hA5;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_color !== 2'b10) begin n_fail++; $display("[TB] FAIL flush_pre: valid %0b color %0d want 1 2", out_valid, out_color); end
    flush = 1'b1; in_data = 8'hFF; in_last = 1'b1; in_valid = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready: got %0b want 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_color !== 2'b00 || frame_cnt !== '0) begin n_fail++; $display("[TB] FAIL flush_cleared: valid %0b color %0d cnt %0d want 0 0 0", out_valid, out_color, frame_cnt); end
    out_ready = 1'b1;
    residue = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) residue++;
      step();
    end
    n_checks++; if (residue != 0) begin n_fail++; $display("[TB] FAIL flush_residue: got %0d colours want 0", residue); end
    in_data = 8'h39; in_last = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_color !== 2'b01) begin n_fail++; $display("[TB] FAIL flush_next_sof: valid %0b sof %0b color %0d want 1 1 1", out_valid, out_sof, out_color); end
    step(); step(); step(); step();
    n_checks++; if (out_valid !== 1'b0 || frame_cnt !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL flush_next_drain: valid %0b cnt %0d want 0 4", out_valid, frame_cnt); end
  endtask

  task automatic test_random();
    exp_t exp_q [$];
    exp_t e;
    logic m_start;
    logic [CNT_W-1:0] m_cnt, cnt_exp;
    logic hs, acc, did_flush, have_cnt;
    int c;
    flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    flush = 1'b0;
    m_start = 1'b1; m_cnt = '0;
    c = 0;
    while (c < 800 || ((exp_q.size() != 0 || out_valid) && c < 1400)) begin
      if (c < 800) begin
        flush     = ($urandom_range(0, 59) == 0);
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 8'($urandom);
        in_last   = ($urandom_range(0, 7) == 0);
        out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      end else begin
        flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      end
      hs = out_valid && out_ready;
      acc = in_valid && in_ready && !flush;
      did_flush = flush;
      have_cnt = 1'b0;
      cnt_exp = '0;
      if (!out_valid) begin
        n_checks++; if ({out_color, out_sof, out_last} !== 4'b0) begin n_fail++; $display("[TB] FAIL rand_idle_outputs: color %0d sof %0b last %0b want 0 0 0", out_color, out_sof, out_last); end
      end
      if (hs) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL rand_unexpected: colour %0d emitted with none expected", out_color);
        end else begin
          e = exp_q.pop_front();
          if ({out_color, out_sof, out_last} !== {e.color, e.sof, e.last}) begin
            n_fail++; $display("[TB] FAIL rand_color: got c%0d s%0b l%0b want c%0d s%0b l%0b", out_color, out_sof, out_last, e.color, e.sof, e.last);
          end
          have_cnt = 1'b1;
          cnt_exp = e.cnt;
        end
      end
      if (did_flush) begin
        exp_q.delete();
        m_start = 1'b1;
        m_cnt = '0;
      end
      if (acc) begin
        for (int k = 0; k < 4; k++) begin
          e.color = in_data[2 * k +: 2];
          e.sof   = m_start;
          e.cnt   = m_start ? CNT_W'(1) : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1'b1);
          e.last  = in_last && (k == 3);
          m_cnt   = e.cnt;
          m_start = e.last;
          exp_q.push_back(e);
        end
      end
      step();
      if (have_cnt) begin
        n_checks++; if (frame_cnt !== cnt_exp) begin n_fail++; $display("[TB] FAIL rand_frame_cnt: got %0d want %0d", frame_cnt, cnt_exp); end
      end
      if (did_flush) begin
        n_checks++; if (out_valid !== 1'b0 || frame_cnt !== '0) begin n_fail++; $display("[TB] FAIL rand_flush: valid %0b cnt %0d want 0 0", out_valid, frame_cnt); end
      end
      c++;
    end
    n_checks++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_drain: %0d colours outstanding, valid %0b want 0 0", exp_q.size(), out_valid); end
  endtask

  // Scenario sequence.
  initial begin
    n_checks = 0;
    n_fail = 0;
    $display("[TB] starting color_unpacker bench");
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
